// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle RV32 subset datapath (R-type, addi, lw, sw, beq).
// One state register drives every datapath enable/select and shares one memory port.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  i_opcode,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_ir_write,
  output logic        o_iord,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_reg_write,
  output logic        o_memtoreg,
  output logic [1:0]  o_alusrca,
  output logic [1:0]  o_alusrcb,
  output logic [1:0]  o_aluop,
  output logic        o_pcsrc,
  output logic [3:0]  o_state,
  output logic        o_illegal,
  output logic [31:0] o_instret
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_retire;
  logic [31:0] r_instret;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  // Memory handshake: a request in FETCH/MEMRD/MEMWR is held with an unchanged
  // address select until mem_ready completes it; mem_ready is ignored elsewhere.
  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    o_pc_write  = 1'b0;
    o_ir_write  = 1'b0;
    o_iord      = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_reg_write = 1'b0;
    o_memtoreg  = 1'b0;
    o_alusrca   = 2'd0;
    o_alusrcb   = 2'd0;
    o_aluop     = 2'd0;
    o_pcsrc     = 1'b0;
    o_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read = 1'b1;
        o_alusrcb  = 2'd2;
        o_ir_write = i_mem_ready;
        o_pc_write = i_mem_ready;
        if (i_mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here from oldPC + imm and parked in ALUOut.
        o_alusrca = 2'd1;
        o_alusrcb = 2'd1;
        case (i_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_ADDI:      w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        o_alusrca = 2'd2;
        o_alusrcb = 2'd1;
        if (i_opcode == OP_LW)      w_next = S_MEMRD;
        else if (i_opcode == OP_SW) w_next = S_MEMWR;
        else                        w_next = S_HALT;
      end
      S_MEMRD: begin
        o_iord     = 1'b1;
        o_mem_read = 1'b1;
        if (i_mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_reg_write = 1'b1;
        o_memtoreg  = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_MEMWR: begin
        o_iord      = 1'b1;
        o_mem_write = 1'b1;
        if (i_mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXECR: begin
        o_alusrca = 2'd2;
        o_aluop   = 2'd2;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        o_alusrca = 2'd2;
        o_alusrcb = 2'd1;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_BEQ: begin
        o_alusrca  = 2'd2;
        o_aluop    = 2'd1;
        o_pcsrc    = 1'b1;
        o_pc_write = i_zero;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_HALT: begin
        o_illegal = 1'b1;
        w_next    = S_HALT;
      end
      default: w_next = S_HALT;
    endcase
  end

  assign o_state   = r_state;
  assign o_instret = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle state/control checks against
// a spec-level model of instruction state walks, plus a retired-instruction count.
module tb_multicycle_control;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  i_opcode = OP_R;
  logic        i_zero = 1'b0;
  logic        i_mem_ready = 1'b0;
  logic        o_pc_write, o_ir_write, o_iord, o_mem_read, o_mem_write;
  logic        o_reg_write, o_memtoreg, o_pcsrc, o_illegal;
  logic [1:0]  o_alusrca, o_alusrcb, o_aluop;
  logic [3:0]  o_state;
  logic [31:0] o_instret;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_cnt = 32'd0;
  logic [3:0]  exp_q[$];
  logic        mr_q[$];

  multicycle_control dut (
    .clk(clk), .rst(rst), .i_opcode(i_opcode), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
    .o_pc_write(o_pc_write), .o_ir_write(o_ir_write), .o_iord(o_iord),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
    .o_memtoreg(o_memtoreg), .o_alusrca(o_alusrca), .o_alusrcb(o_alusrcb),
    .o_aluop(o_aluop), .o_pcsrc(o_pcsrc), .o_state(o_state), .o_illegal(o_illegal),
    .o_instret(o_instret)
  );

  always #5 clk = ~clk;

  // Control word order: pcw irw iord mrd mwr rw m2r a[1:0] b[1:0] op[1:0] pcsrc illegal
  function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z);
    logic pcw, irw, iord, mrd, mwr, rw, m2r, pcs, ill;
    logic [1:0] a, b, op;
    {pcw, irw, iord, mrd, mwr, rw, m2r, pcs, ill} = '0;
    a = 2'd0; b = 2'd0; op = 2'd0;
    case (st)
      4'd0:  begin mrd = 1'b1; b = 2'd2; pcw = mr; irw = mr; end
      4'd1:  begin a = 2'd1; b = 2'd1; end
      4'd2:  begin a = 2'd2; b = 2'd1; end
      4'd3:  begin iord = 1'b1; mrd = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin iord = 1'b1; mwr = 1'b1; end
      4'd6:  begin a = 2'd2; op = 2'd2; end
      4'd7:  begin a = 2'd2; b = 2'd1; end
      4'd8:  rw = 1'b1;
      4'd9:  begin a = 2'd2; op = 2'd1; pcs = 1'b1; pcw = z; end
      default: ill = 1'b1;
    endcase
    return {pcw, irw, iord, mrd, mwr, rw, m2r, a, b, op, pcs, ill};
  endfunction

  function automatic logic [14:0] act_ctrl();
    return {o_pc_write, o_ir_write, o_iord, o_mem_read, o_mem_write, o_reg_write,
            o_memtoreg, o_alusrca, o_alusrcb, o_aluop, o_pcsrc, o_illegal};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; i_mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_cnt = 32'd0;
  endtask

  // Builds the expected state walk for one instruction and checks every cycle.
  task automatic run_instr(input logic [6:0] op, input logic z, input int fs, input int ms);
    logic legal;
    exp_q.delete(); mr_q.delete();
    for (int i = 0; i < fs; i++) begin exp_q.push_back(4'd0); mr_q.push_back(1'b0); end
    exp_q.push_back(4'd0); mr_q.push_back(1'b1);
    exp_q.push_back(4'd1); mr_q.push_back(1'($urandom_range(0, 1)));
    legal = 1'b1;
    case (op)
      OP_R:    begin exp_q.push_back(4'd6); exp_q.push_back(4'd8); end
      OP_ADDI: begin exp_q.push_back(4'd7); exp_q.push_back(4'd8); end
      OP_BEQ:  exp_q.push_back(4'd9);
      OP_LW: begin
        exp_q.push_back(4'd2); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < ms; i++) begin exp_q.push_back(4'd3); mr_q.push_back(1'b0); end
        exp_q.push_back(4'd3); mr_q.push_back(1'b1);
        exp_q.push_back(4'd4);
      end
      OP_SW: begin
        exp_q.push_back(4'd2); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < ms; i++) begin exp_q.push_back(4'd5); mr_q.push_back(1'b0); end
        exp_q.push_back(4'd5); mr_q.push_back(1'b1);
      end
      default: begin exp_q.push_back(4'd10); legal = 1'b0; end
    endcase
    while (mr_q.size() < exp_q.size()) mr_q.push_back(1'($urandom_range(0, 1)));
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      i_opcode = op; i_zero = z; i_mem_ready = mr_q[c];
      #1;
      total++;
      if (o_state !== exp_q[c]) begin
        bad++;
        $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", op, c, o_state, exp_q[c]);
      end
      total++;
      if (act_ctrl() !== exp_ctrl(exp_q[c], mr_q[c], z)) begin
        bad++;
        $display("FAIL ctrl op=%b cyc=%0d st=%0d got=%b want=%b", op, c, exp_q[c], act_ctrl(),
                 exp_ctrl(exp_q[c], mr_q[c], z));
      end
      total++;
      if (o_instret !== model_cnt) begin
        bad++;
        $display("FAIL instret_hold op=%b cyc=%0d got=%h want=%h", op, c, o_instret, model_cnt);
      end
      total++;
      if ({o_mem_read & o_mem_write, o_reg_write & o_pc_write} !== 2'b00) begin
        bad++;
        $display("FAIL exclusive op=%b cyc=%0d mrd=%b mwr=%b rw=%b pcw=%b", op, c,
                 o_mem_read, o_mem_write, o_reg_write, o_pc_write);
      end
    end
    if (legal) begin
      model_cnt = model_cnt + 32'd1;
      @(negedge clk);
      i_mem_ready = 1'b0;
      #1;
      total++;
      if (o_state !== 4'd0 || o_instret !== model_cnt) begin
        bad++;
        $display("FAIL retire op=%b got st=%0d cnt=%h want st=0 cnt=%h", op, o_state,
                 o_instret, model_cnt);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (o_state !== 4'd0 || o_instret !== 32'd0 || act_ctrl() !== 15'b000100000100000) begin
      bad++;
      $display("FAIL reset st=%0d cnt=%h ctrl=%b want st=0 cnt=0 ctrl=000100000100000",
               o_state, o_instret, act_ctrl());
    end
  endtask

  task automatic test_rtype();
    run_instr(OP_R, 1'b0, 0, 0);
    total++;
    if (o_instret !== 32'd1) begin
      bad++;
      $display("FAIL rtype_count got=%h want=1", o_instret);
    end
  endtask

  task automatic test_lw_stall();
    run_instr(OP_LW, 1'b0, 0, 2);
    run_instr(OP_ADDI, 1'b1, 0, 0);
  endtask

  task automatic test_beq();
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
  endtask

  task automatic test_sw_fetch_stall();
    run_instr(OP_SW, 1'b0, 1, 0);
    run_instr(OP_SW, 1'b1, 2, 2);
  endtask

  task automatic test_random();
    logic [6:0] ops[5];
    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ};
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  task automatic test_wrap();
    @(negedge clk);
    i_mem_ready = 1'b0;
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    model_cnt = 32'hFFFF_FFFF;
    run_instr(OP_R, 1'b0, 0, 0);
    total++;
    if (o_instret !== 32'd0) begin
      bad++;
      $display("FAIL wrap got=%h want=00000000", o_instret);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [3:0] walk[4];
    walk = '{4'd0, 4'd1, 4'd2, 4'd5};
    i_opcode = OP_SW;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      i_mem_ready = (c == 0);
      #1;
      total++;
      if (o_state !== walk[c]) begin
        bad++;
        $display("FAIL store_walk cyc=%0d got=%0d want=%0d", c, o_state, walk[c]);
      end
    end
    total++;
    if (o_mem_write !== 1'b1) begin
      bad++;
      $display("FAIL store_req got=%b want=1", o_mem_write);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_cnt = 32'd0;
    #1;
    total++;
    if (o_state !== 4'd0 || o_mem_write !== 1'b0 || o_instret !== 32'd0) begin
      bad++;
      $display("FAIL store_reset st=%0d mwr=%b cnt=%h want st=0 mwr=0 cnt=0",
               o_state, o_mem_write, o_instret);
    end
  endtask

  task automatic test_illegal_halt();
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_BAD, 1'b0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      i_mem_ready = 1'($urandom_range(0, 1));
      i_zero = 1'($urandom_range(0, 1));
      i_opcode = 7'($urandom);
      #1;
      total++;
      if (o_state !== 4'd10 || act_ctrl() !== 15'b000000000000001 || o_instret !== model_cnt) begin
        bad++;
        $display("FAIL halt cyc=%0d st=%0d ctrl=%b cnt=%h want st=10 ctrl=000000000000001 cnt=%h",
                 c, o_state, act_ctrl(), o_instret, model_cnt);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    i_mem_ready = 1'b0;
    #1;
    total++;
    if (o_state !== 4'd0 || o_illegal !== 1'b0 || o_instret !== 32'd0) begin
      bad++;
      $display("FAIL halt_exit st=%0d ill=%b cnt=%h want st=0 ill=0 cnt=0",
               o_state, o_illegal, o_instret);
    end
    model_cnt = 32'd0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_sw_fetch_stall();
    test_random();
    test_wrap();
    test_reset_mid_store();
    test_illegal_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
